axi4_lite_master: RTL and testbench
===================================

Name: axi4_lite_master

Overview:
- AXI4-Lite initiator that drives the S_-side slave port through a single-outstanding command/response interface.
- A testbench driver or an on-chip controller issues one read or write command.
- The block runs the AW/W/B or AR/R channel handshakes and returns read data and response status.
- Exactly one transaction is in flight at a time; there is no reordering and no pipelining across commands.

Parameters:
ADDR_WIDTH, 5, width of AWADDR/ARADDR and cmd_addr
DATA_WIDTH, 32, width of WDATA/RDATA, cmd_wdata and rsp_rdata

Ports:
ACLK  in  1  clock; all logic is on the rising edge
ARESET  in  1  reset; synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_err  out  1  captured RRESP/BRESP (1 = error)
M_AWADDR  out  ADDR_WIDTH  write address
M_AWVALID  out  1  write address valid
M_AWREADY  in  1  write address ready
M_WDATA  out  DATA_WIDTH  write data
M_WVALID  out  1  write data valid
M_WREADY  in  1  write data ready
M_BVALID  in  1  write response valid
M_BREADY  out  1  write response ready
M_BRESP  in  1  write response (1 = error)
M_ARADDR  out  ADDR_WIDTH  read address
M_ARVALID  out  1  read address valid
M_ARREADY  in  1  read address ready
M_RVALID  in  1  read data valid
M_RREADY  out  1  read data ready
M_RDATA  in  DATA_WIDTH  read data
M_RRESP  in  1  read response (1 = error)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - state = IDLE.
  - All VALID/READY outputs, rsp_valid, rsp_write and rsp_err are 0; addresses and data are 0.
  - cmd_ready = 1 in the first cycle after reset is released.
- ARESET mid-transaction abandons the transaction: outputs return to their reset values on the next edge and no response is produced.
- Every output is registered.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch addr/wdata/write.
  - Write: next state WADDR, with M_AWVALID = M_WVALID = 1 from the next cycle.
  - Read: next state RADDR, with M_ARVALID = 1 from the next cycle.
  - cmd_ready = 0 in every state except IDLE.
- WADDR:
  - AW and W complete independently.
  - Each VALID drops on the edge where its READY is sampled high; the other keeps waiting.
  - AWADDR and WDATA are stable while their VALID is high.
  - Once both have completed (same cycle or different cycles), go to WRESP with M_BREADY = 1 from the next cycle.
- WRESP:
  - M_BREADY = 1.
  - On M_BVALID, capture BRESP into rsp_err, set rsp_write = 1, rsp_rdata = 0, M_BREADY <= 0, go to RSP.
- RADDR:
  - M_ARVALID held until M_ARREADY.
  - Then M_ARVALID <= 0, M_RREADY <= 1, go to RDATA.
- RDATA:
  - On M_RVALID && M_RREADY, capture RDATA into rsp_rdata and RRESP into rsp_err.
  - Set rsp_write = 0, M_RREADY <= 0, go to RSP.
- RSP:
  - rsp_valid = 1; response fields are held stable until rsp_ready.
  - On rsp_ready: rsp_valid <= 0, cmd_ready <= 1, go to IDLE.
  - A new command is not accepted in the same cycle as the response handshake.
- Minimum latency with all slave READY/VALID tied high:
  - Write: cmd handshake at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
  - Read: AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.
- The block never asserts VALID combinationally from an input READY.
- The block never drops VALID before its handshake.

Test Plan:
1. Write addr 0x04, data 0xDEADBEEF, slave READY tied 1, BRESP = 0:
   - AW/W handshake at cycle 1, BREADY at cycle 2.
   - rsp_valid at cycle 3 with rsp_write = 1, rsp_err = 0.
2. Read addr 0x04 after test 1, slave returns 0xDEADBEEF, RRESP = 0:
   - ARVALID at cycle 1, rsp_valid at cycle 3.
   - rsp_rdata = 0xDEADBEEF, rsp_write = 0.
3. Write with AWREADY delayed 3 cycles and WREADY delayed 1 cycle:
   - WVALID drops after cycle 2; AWVALID is held with a stable address until cycle 4.
   - BREADY rises at cycle 5.
4. Read with RRESP = 1 and rsp_ready held low for 4 cycles:
   - rsp_err = 1 and rsp_rdata are held stable for all 4 cycles.
   - cmd_ready stays 0 until the cycle after rsp_ready.
5. ARESET pulsed in WRESP while BVALID = 0:
   - Next cycle all outputs are 0 and cmd_ready = 1.
   - No rsp_valid is ever produced for the aborted write.
6. Back-to-back write 0x1F/0x00000001, then read 0x1F, with rsp_ready tied 1:
   - Second cmd is accepted exactly 1 cycle after the first response handshake.
   - Read returns 0x00000001.

Source files
------------

// File: rtl/axi4_lite_master_if.sv
// axi4_lite_master_if: bundles the command/response port and the AXI4-Lite
// initiator port of axi4_lite_master.
//
// Groups:
//   cmd_*  : one command from a driver or controller (cmd_valid/cmd_ready)
//   rsp_*  : the single response for that command (rsp_valid/rsp_ready)
//   M_AW*, M_W*, M_B*, M_AR*, M_R* : AXI4-Lite channels towards the slave
//
// Handshake rule for every VALID/READY pair here: a transfer happens on a
// rising edge where both are 1. The source holds VALID and its payload stable
// until that edge, and never makes VALID depend on READY in the same cycle.
//
// Modports:
//   master : the initiator block's view
//   slave  : the environment's view (command source, response sink, slave)
interface axi4_lite_master_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] M_AWADDR;
  logic                  M_AWVALID;
  logic                  M_AWREADY;
  logic [DATA_WIDTH-1:0] M_WDATA;
  logic                  M_WVALID;
  logic                  M_WREADY;
  logic                  M_BVALID;
  logic                  M_BREADY;
  logic                  M_BRESP;
  logic [ADDR_WIDTH-1:0] M_ARADDR;
  logic                  M_ARVALID;
  logic                  M_ARREADY;
  logic                  M_RVALID;
  logic                  M_RREADY;
  logic [DATA_WIDTH-1:0] M_RDATA;
  logic                  M_RRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
    input  M_ARREADY, M_RVALID, M_RDATA, M_RRESP,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output M_AWADDR, M_AWVALID, M_WDATA, M_WVALID, M_BREADY,
    output M_ARADDR, M_ARVALID, M_RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
    output M_ARREADY, M_RVALID, M_RDATA, M_RRESP,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  M_AWADDR, M_AWVALID, M_WDATA, M_WVALID, M_BREADY,
    input  M_ARADDR, M_ARVALID, M_RREADY
  );
endinterface

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite initiator.
//
// Accepts one read or write command on bus.cmd_*, runs the AW/W/B or AR/R
// handshakes on bus.M_*, and returns status (and read data) on bus.rsp_*.
// Exactly one transaction is in flight; a new command is only taken in IDLE.
//
// Ports:
//   ACLK      : clock, rising edge
//   ARESET    : synchronous, active-high reset; abandons any transaction
//   bus       : axi4_lite_master_if.master (command, response, AXI channels)
//   dbg_state : current FSM state (IDLE=0 WADDR=1 WRESP=2 RADDR=3 RDATA=4 RSP=5)
//
// All outputs are registered in the single FSM process below.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  axi4_lite_master_if.master        bus,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t state;

  // AW and W finish independently; a channel counts as finished once its
  // VALID has dropped or its handshake is happening on this edge.
  logic aw_complete;
  logic w_complete;

  assign aw_complete = !bus.M_AWVALID || bus.M_AWREADY;
  assign w_complete  = !bus.M_WVALID  || bus.M_WREADY;
  assign dbg_state   = state;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      // Ready for a command in the first cycle after reset is released.
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
      bus.rsp_err   <= 1'b0;
      bus.M_AWADDR  <= {ADDR_WIDTH{1'b0}};
      bus.M_AWVALID <= 1'b0;
      bus.M_WDATA   <= {DATA_WIDTH{1'b0}};
      bus.M_WVALID  <= 1'b0;
      bus.M_BREADY  <= 1'b0;
      bus.M_ARADDR  <= {ADDR_WIDTH{1'b0}};
      bus.M_ARVALID <= 1'b0;
      bus.M_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (bus.cmd_write) begin
              bus.M_AWADDR  <= bus.cmd_addr;
              bus.M_WDATA   <= bus.cmd_wdata;
              bus.M_AWVALID <= 1'b1;
              bus.M_WVALID  <= 1'b1;
              state         <= WADDR;
            end else begin
              bus.M_ARADDR  <= bus.cmd_addr;
              bus.M_ARVALID <= 1'b1;
              state         <= RADDR;
            end
          end
        end

        WADDR: begin
          if (bus.M_AWVALID && bus.M_AWREADY) begin
            bus.M_AWVALID <= 1'b0;
          end
          if (bus.M_WVALID && bus.M_WREADY) begin
            bus.M_WVALID <= 1'b0;
          end
          if (aw_complete && w_complete) begin
            bus.M_BREADY <= 1'b1;
            state        <= WRESP;
          end
        end

        WRESP: begin
          // BREADY is held high throughout this state, so BVALID alone
          // marks the handshake edge.
          if (bus.M_BVALID) begin
            bus.rsp_err   <= bus.M_BRESP;
            bus.rsp_write <= 1'b1;
            bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
            bus.rsp_valid <= 1'b1;
            bus.M_BREADY  <= 1'b0;
            state         <= RSP;
          end
        end

        RADDR: begin
          if (bus.M_ARREADY) begin
            bus.M_ARVALID <= 1'b0;
            bus.M_RREADY  <= 1'b1;
            state         <= RDATA;
          end
        end

        RDATA: begin
          if (bus.M_RVALID && bus.M_RREADY) begin
            bus.rsp_rdata <= bus.M_RDATA;
            bus.rsp_err   <= bus.M_RRESP;
            bus.rsp_write <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.M_RREADY  <= 1'b0;
            state         <= RSP;
          end
        end

        RSP: begin
          // cmd_ready rises only on the next edge, so a new command can never
          // be taken in the same cycle as the response handshake.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: self-checking bench for axi4_lite_master.
// A vector table drives commands; a slave model with per-vector delays and
// response codes answers on the AXI channels; a monitor pops expected
// responses from a queue and checks channel stability every cycle.
module tb_axi4_lite_master;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int EW = DW + 2;
  localparam int OW = 83;
  localparam logic [OW-1:0] RESET_OUTS = {1'b1, {(OW-1){1'b0}}};

  // ---------------- clock / reset ----------------
  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [2:0] dbg_state;
  int         cyc = 0;

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  axi4_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  int last_hs = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] outs();
    return {bus.cmd_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.rsp_rdata,
            bus.M_AWADDR, bus.M_AWVALID, bus.M_WDATA, bus.M_WVALID, bus.M_BREADY,
            bus.M_ARADDR, bus.M_ARVALID, bus.M_RREADY};
  endfunction

  // ---------------- slave model ----------------
  int   cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic cfg_bresp = 1'b0, cfg_rresp = 1'b0;

  logic [DW-1:0] mem [32];
  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit            aw_done, w_done, ar_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          s_bready, s_rready;

  task automatic slave_clear();
    bus.M_AWREADY = 1'b0;
    bus.M_WREADY  = 1'b0;
    bus.M_BVALID  = 1'b0;
    bus.M_BRESP   = 1'b0;
    bus.M_ARREADY = 1'b0;
    bus.M_RVALID  = 1'b0;
    bus.M_RDATA   = '0;
    bus.M_RRESP   = 1'b0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_done = 0; w_done = 0; ar_done = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  // Acts #1 after each falling edge; a READY raised while VALID is high
  // always completes on the following rising edge.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    slave_clear();
    s_bready = 1'b0;
    s_rready = 1'b0;
    forever begin
      @(negedge ACLK);
      #1;
      if (ARESET) begin
        slave_clear();
      end else begin
        if (bus.M_AWREADY) begin
          bus.M_AWREADY = 1'b0; aw_done = 1; aw_cnt = 0;
        end else if (bus.M_AWVALID) begin
          if (aw_cnt >= cfg_aw_dly) begin bus.M_AWREADY = 1'b1; wr_addr = bus.M_AWADDR; end
          else aw_cnt++;
        end
        if (bus.M_WREADY) begin
          bus.M_WREADY = 1'b0; w_done = 1; w_cnt = 0;
        end else if (bus.M_WVALID) begin
          if (w_cnt >= cfg_w_dly) begin bus.M_WREADY = 1'b1; wr_data = bus.M_WDATA; end
          else w_cnt++;
        end
        if (bus.M_BVALID) begin
          if (s_bready) begin
            bus.M_BVALID = 1'b0; bus.M_BRESP = 1'b0; aw_done = 0; w_done = 0; b_cnt = 0;
          end
        end else if (aw_done && w_done) begin
          if (b_cnt >= cfg_b_dly) begin
            bus.M_BVALID = 1'b1;
            bus.M_BRESP  = cfg_bresp;
            if (!cfg_bresp) mem[wr_addr] = wr_data;
          end else b_cnt++;
        end
        if (bus.M_ARREADY) begin
          bus.M_ARREADY = 1'b0; ar_done = 1; ar_cnt = 0;
        end else if (bus.M_ARVALID) begin
          if (ar_cnt >= cfg_ar_dly) begin bus.M_ARREADY = 1'b1; rd_addr = bus.M_ARADDR; end
          else ar_cnt++;
        end
        if (bus.M_RVALID) begin
          if (s_rready) begin
            bus.M_RVALID = 1'b0; bus.M_RRESP = 1'b0; bus.M_RDATA = '0; ar_done = 0; r_cnt = 0;
          end
        end else if (ar_done) begin
          if (r_cnt >= cfg_r_dly) begin
            bus.M_RVALID = 1'b1;
            bus.M_RDATA  = mem[rd_addr];
            bus.M_RRESP  = cfg_rresp;
          end else r_cnt++;
        end
      end
      s_bready = bus.M_BREADY;
      s_rready = bus.M_RREADY;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic          prev_rst = 1'b1;
  logic          prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, prev_arv = 0, prev_arr = 0;
  logic [AW-1:0] prev_awaddr = '0, prev_araddr = '0;
  logic [DW-1:0] prev_wdata = '0;
  logic [EW-1:0] exp_w;

  initial begin
    forever begin
      @(negedge ACLK);
      #2;
      if (!ARESET && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {127'd0, bus.rsp_valid}, 128'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check("rsp_fields", {bus.rsp_write, bus.rsp_err, bus.rsp_rdata}, exp_w);
        end
      end
      if (!prev_rst) begin
        if (prev_awv && !prev_awr) check("aw_hold", {bus.M_AWVALID, bus.M_AWADDR}, {1'b1, prev_awaddr});
        if (prev_wv && !prev_wr)   check("w_hold", {bus.M_WVALID, bus.M_WDATA}, {1'b1, prev_wdata});
        if (prev_arv && !prev_arr) check("ar_hold", {bus.M_ARVALID, bus.M_ARADDR}, {1'b1, prev_araddr});
      end
      prev_rst    = ARESET;
      prev_awv    = bus.M_AWVALID;  prev_awr = bus.M_AWREADY;  prev_awaddr = bus.M_AWADDR;
      prev_wv     = bus.M_WVALID;   prev_wr  = bus.M_WREADY;   prev_wdata  = bus.M_WDATA;
      prev_arv    = bus.M_ARVALID;  prev_arr = bus.M_ARREADY;  prev_araddr = bus.M_ARADDR;
    end
  end

  // ---------------- vectors / driver ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic          bresp, rresp;
    int            hold;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] exp_mem [32];

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input int aw, input int w, input int b, input int ar, input int r,
                              input logic bresp, input logic rresp, input int hold,
                              input logic [DW-1:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.aw_dly = aw; v.w_dly = w; v.b_dly = b; v.ar_dly = ar; v.r_dly = r;
    v.bresp = bresp; v.rresp = rresp; v.hold = hold;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs.push_back(v);
    if (v.wr && !v.bresp) exp_mem[v.addr] = v.wdata;
  endtask

  task automatic run_vec(input vec_t v, input bit gap_chk);
    int guard;
    int acc;
    cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
    cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly;
    cfg_bresp  = v.bresp;  cfg_rresp = v.rresp;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    guard = 0;
    while (!bus.cmd_ready && guard < 200) begin @(negedge ACLK); guard++; end
    if (!bus.cmd_ready) begin
      check("cmd_timeout", {127'd0, bus.cmd_ready}, 128'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    exp_q.push_back({v.wr, v.exp_err, v.exp_rdata});
    if (gap_chk) check("cmd_gap", acc - last_hs, 1);
    bus.rsp_ready = (v.hold == 0);
    @(negedge ACLK);
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = $urandom;
    guard = 0;
    while (!bus.rsp_valid && guard < 200) begin @(negedge ACLK); guard++; end
    if (!bus.rsp_valid) begin
      check("rsp_timeout", {127'd0, bus.rsp_valid}, 128'd1);
      bus.rsp_ready = 1'b1;
      return;
    end
    check("latency", cyc - acc, v.exp_lat);
    for (int k = 0; k < v.hold; k++) begin
      check("rsp_hold", {bus.rsp_valid, bus.cmd_ready, bus.rsp_write, bus.rsp_err, bus.rsp_rdata},
            {1'b1, 1'b0, v.wr, v.exp_err, v.exp_rdata});
      @(negedge ACLK);
    end
    bus.rsp_ready = 1'b1;
    last_hs = cyc;
    if (v.hold > 0) begin
      @(negedge ACLK);
      check("cmd_ready_after_rsp", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  guard;
    bit  seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    ARESET        = 1'b1;

    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    add(mk(1, 5'h04, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 3));
    add(mk(0, 5'h04, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 3));
    add(mk(1, 5'h08, 32'h12345678, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 6));
    add(mk(0, 5'h08, 32'h0,        0, 0, 0, 0, 0, 0, 1, 4, 32'h12345678, 1, 3));
    add(mk(1, 5'h10, 32'hCAFEF00D, 0, 0, 2, 0, 0, 1, 0, 0, 32'h0,        1, 5));
    add(mk(1, 5'h1F, 32'h00000001, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 3));
    add(mk(0, 5'h1F, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 32'h00000001, 0, 3));
    add(mk(0, 5'h00, 32'h0,        0, 0, 0, 2, 1, 0, 0, 0, 32'h0,        0, 6));
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int aw, w, b, ar, r;
      a  = AW'($urandom_range(0, 31));
      d  = $urandom;
      aw = $urandom_range(0, 3); w = $urandom_range(0, 3); b = $urandom_range(0, 3);
      ar = $urandom_range(0, 3); r = $urandom_range(0, 3);
      add(mk(1, a, d, aw, w, b, 0, 0, 0, 0, 0, 32'h0, 0, 3 + ((aw > w) ? aw : w) + b));
      add(mk(0, a, 32'h0, 0, 0, 0, ar, r, 0, 0, 0, exp_mem[a], 0, 3 + ar + r));
    end

    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("reset_outputs", outs(), RESET_OUTS);
    check("reset_state", dbg_state, 3'd0);

    foreach (vecs[i]) begin
      run_vec(vecs[i], (i > 0) && (vecs[i > 0 ? i - 1 : 0].hold == 0));
    end

    // Reset while waiting for a write response that never comes.
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 20; cfg_bresp = 0;
    @(negedge ACLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 5'h0C;
    bus.cmd_wdata = 32'hA5A5A5A5;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin @(negedge ACLK); guard++; end
    @(negedge ACLK);
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (!bus.M_BREADY && guard < 50) begin @(negedge ACLK); guard++; end
    check("abort_in_wresp", {bus.M_BREADY, bus.M_BVALID}, 2'b10);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check("abort_outputs", outs(), RESET_OUTS);
    seen = 0;
    repeat (25) begin
      @(negedge ACLK);
      if (bus.rsp_valid) seen = 1;
    end
    check("abort_no_rsp", {127'd0, seen}, 128'd0);

    // The block must be usable again and the aborted write must not land.
    run_vec(mk(0, 5'h0C, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, exp_mem[12], 0, 3), 1'b0);
    run_vec(mk(0, 5'h1F, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, exp_mem[31], 0, 3), 1'b1);

    repeat (3) @(negedge ACLK);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
